rdmap_wqe_sched: RTL

- Parametrised multi-queue-pair work-queue-element (WQE) scheduler for the RDMAP layer.
- Generalises the single SQ/RQ pair to NUM_QP show-ahead WQE queues.
- Selects one eligible queue, pops its head WQE and pushes it, tagged with the queue id, into the single downstream DMA request FIFO.
- Supports round-robin with a per-queue burst limit, or strict priority, selectable at run time.

---
 rtl/rdmap_wqe_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rdmap_wqe_sched.sv
// rdmap_wqe_sched: multi-queue-pair WQE scheduler. Picks one eligible
// show-ahead work queue (round-robin with burst limit, or strict priority),
// pops its head WQE and pushes it, tagged with its queue id, into the
// single downstream DMA request FIFO.
module rdmap_wqe_sched #(
    parameter int NUM_QP = 4,
    parameter int QID_W  = 2,
    parameter int WQE_W  = 112,
    parameter int BURST  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_QP-1:0]         qEmpty,
    input  logic [NUM_QP*WQE_W-1:0]   qData,
    output logic [NUM_QP-1:0]         qPop,
    input  logic [NUM_QP-1:0]         qEnable,
    input  logic                      prioMode,
    input  logic                      outFull,
    output logic                      outPush,
    output logic [WQE_W-1:0]          outData,
    output logic [QID_W-1:0]          outQid,
    output logic                      busy,
    output logic [15:0]               grantTotal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    localparam logic [3:0]       BurstLim = 4'(BURST);
    localparam logic [QID_W:0]   NumQpW   = (QID_W+1)'(NUM_QP);
    localparam logic [QID_W-1:0] LastQid  = QID_W'(NUM_QP - 1);

    state_t              state;
    state_t              stateNext;
    logic [QID_W-1:0]    sel;
    logic [QID_W-1:0]    selNext;
    logic [QID_W-1:0]    rrPtr;
    logic [QID_W-1:0]    rrPtrNext;
    logic [3:0]          burstCnt;
    logic [3:0]          burstCntNext;
    logic [NUM_QP-1:0]   elig;
    logic [QID_W-1:0]    prioSel;
    logic                prioFound;
    logic [2*NUM_QP-1:0] eligDbl;
    logic [NUM_QP-1:0]   eligRot;
    logic [QID_W-1:0]    rrOfs;
    logic                rrFound;
    logic [QID_W:0]      rrSum;
    logic [QID_W-1:0]    rrSel;
    logic [WQE_W-1:0]    qWord [NUM_QP];
    logic                pushNow;

    assign elig    = qEnable & ~qEmpty;
    assign pushNow = (state == PUSH) && !outFull;
    assign outPush = pushNow && !reset;
    assign busy    = (state != IDLE);

    // Split the flat head-WQE bus into one word per queue.
    always_comb begin
        for (int unsigned i = 0; i < NUM_QP; i++) begin
            qWord[i] = qData[i*WQE_W +: WQE_W];
        end
    end

    // Strict priority pick: lowest eligible index.
    always_comb begin
        prioSel   = '0;
        prioFound = 1'b0;
        for (int unsigned i = 0; i < NUM_QP; i++) begin
            if (elig[i] && !prioFound) begin
                prioSel   = QID_W'(i);
                prioFound = 1'b1;
            end
        end
    end

    // Round-robin pick: rotate elig so rrPtr lands at bit 0, find the first
    // set bit, then add the offset back modulo NUM_QP.
    always_comb begin
        eligDbl = {elig, elig} >> rrPtr;
        eligRot = eligDbl[NUM_QP-1:0];
        rrOfs   = '0;
        rrFound = 1'b0;
        for (int unsigned i = 0; i < NUM_QP; i++) begin
            if (eligRot[i] && !rrFound) begin
                rrOfs   = QID_W'(i);
                rrFound = 1'b1;
            end
        end
        rrSum = {1'b0, rrPtr} + {1'b0, rrOfs};
        if (rrSum >= NumQpW) begin
            rrSum = rrSum - NumQpW;
        end
        rrSel = rrSum[QID_W-1:0];
    end

    // Next-state, selection, burst and round-robin pointer update.
    always_comb begin
        stateNext    = state;
        selNext      = sel;
        rrPtrNext    = rrPtr;
        burstCntNext = burstCnt;
        case (state)
            IDLE: begin
                if (|elig) begin
                    selNext      = prioMode ? prioSel : rrSel;
                    burstCntNext = 4'd1;
                    stateNext    = POP;
                end
            end
            POP: begin
                stateNext = PUSH;
            end
            PUSH: begin
                if (!outFull) begin
                    if (!prioMode && elig[sel] && (burstCnt < BurstLim)) begin
                        burstCntNext = burstCnt + 4'd1;
                        stateNext    = POP;
                    end else if (prioMode) begin
                        if (|elig) begin
                            selNext      = prioSel;
                            burstCntNext = 4'd1;
                            stateNext    = POP;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        rrPtrNext = (sel == LastQid) ? '0 : sel + QID_W'(1);
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // One-hot pop strobe decoded from registered state; suppressed during reset.
    always_comb begin
        qPop = '0;
        for (int unsigned i = 0; i < NUM_QP; i++) begin
            qPop[i] = (state == POP) && !reset && (sel == QID_W'(i));
        end
    end

    // State, pointers, captured WQE and grant counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            rrPtr      <= '0;
            burstCnt   <= '0;
            outData    <= '0;
            outQid     <= '0;
            grantTotal <= '0;
        end else begin
            state    <= stateNext;
            sel      <= selNext;
            rrPtr    <= rrPtrNext;
            burstCnt <= burstCntNext;
            if (state == POP) begin
                outData <= qWord[sel];
                outQid  <= sel;
            end
            if (pushNow) begin
                grantTotal <= grantTotal + 16'd1;
            end
        end
    end

endmodule
